// File: rtl/em_reg_pkg.sv
// rtl/em_reg_pkg.sv - shared ExcCode constants, mem_op encodings and op-class helpers
package em_reg_pkg;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   typedef enum logic [3:0] {
      MEM_NONE = 4'd0,
      MEM_LW   = 4'd1,
      MEM_LH   = 4'd2,
      MEM_LHU  = 4'd3,
      MEM_LB   = 4'd4,
      MEM_LBU  = 4'd5,
      MEM_SW   = 4'd6,
      MEM_SH   = 4'd7,
      MEM_SB   = 4'd8
   } mem_op_t;

   function automatic logic is_load(input logic [3:0] op);
      return (op >= 4'(MEM_LW)) && (op <= 4'(MEM_LBU));
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op >= 4'(MEM_SW)) && (op <= 4'(MEM_SB));
   endfunction

endpackage

// File: rtl/store_align.sv
// rtl/store_align.sv - store data replication, byte enables and alignment check
module store_align
   import em_reg_pkg::*;
(
   input  logic [3:0]  mem_op,
   input  logic [1:0]  addr,
   input  logic [31:0] rt_data,
   output logic [31:0] wdata,
   output logic [3:0]  be,
   output logic        align_err
);

   always_comb begin
      wdata     = rt_data;
      be        = 4'b0000;
      align_err = 1'b0;
      case (mem_op)
         MEM_LW: align_err = |addr;
         MEM_LH, MEM_LHU: align_err = addr[0];
         MEM_SW: begin
            align_err = |addr;
            be        = 4'b1111;
         end
         MEM_SH: begin
            align_err = addr[0];
            wdata     = {2{rt_data[15:0]}};
            be        = addr[1] ? 4'b1100 : 4'b0011;
         end
         MEM_SB: begin
            wdata = {4{rt_data[7:0]}};
            be    = 4'b0001 << addr;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/em_reg.sv
// rtl/em_reg.sv - E/M pipeline register with address-error and overflow ExcCode generation
module em_reg
   import em_reg_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_E,
   input  logic [31:0] pc_E,
   input  logic [31:0] alu_c_E,
   input  logic [31:0] rt_data_E,
   input  logic [4:0]  a3_E,
   input  logic [4:0]  exc_E,
   input  logic        bd_E,
   input  logic        cal_overflow_E,
   input  logic        ov_en_E,
   input  logic [3:0]  mem_op_E,
   input  logic        valid_E,
   input  logic        stall_M,
   input  logic        bubble_E,
   input  logic        flush,
   output logic [31:0] instr_M,
   output logic [31:0] pc_M,
   output logic [31:0] alu_M,
   output logic [31:0] wdata_M,
   output logic [4:0]  a3_M,
   output logic [4:0]  exc_M,
   output logic [3:0]  be_M,
   output logic        bd_M,
   output logic        valid_M,
   output logic [3:0]  mem_op_M
);

   logic [31:0] sa_wdata;
   logic [3:0]  sa_be;
   logic        sa_align_err;
   logic        ld_op;
   logic        st_op;
   logic [4:0]  exc_next;
   logic [3:0]  be_next;

   store_align u_store_align (
      .mem_op    (mem_op_E),
      .addr      (alu_c_E[1:0]),
      .rt_data   (rt_data_E),
      .wdata     (sa_wdata),
      .be        (sa_be),
      .align_err (sa_align_err)
   );

   // An overflowing address calculation is reported as an address error, not Ov.
   always_comb begin
      ld_op    = is_load(mem_op_E);
      st_op    = is_store(mem_op_E);
      exc_next = EXC_INT;
      if (exc_E != EXC_INT)
         exc_next = exc_E;
      else if ((ld_op || st_op) && (sa_align_err || cal_overflow_E))
         exc_next = ld_op ? EXC_ADEL : EXC_ADES;
      else if (ov_en_E && cal_overflow_E)
         exc_next = EXC_OV;
      be_next = (st_op && valid_E && (exc_next == EXC_INT)) ? sa_be : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         instr_M  <= '0;
         pc_M     <= '0;
         alu_M    <= '0;
         wdata_M  <= '0;
         a3_M     <= '0;
         exc_M    <= EXC_INT;
         be_M     <= '0;
         bd_M     <= 1'b0;
         valid_M  <= 1'b0;
         mem_op_M <= MEM_NONE;
      end else if (flush) begin
         instr_M  <= '0;
         pc_M     <= '0;
         alu_M    <= '0;
         wdata_M  <= '0;
         a3_M     <= '0;
         exc_M    <= EXC_INT;
         be_M     <= '0;
         bd_M     <= 1'b0;
         valid_M  <= 1'b0;
         mem_op_M <= MEM_NONE;
      end else if (!stall_M) begin
         if (bubble_E) begin
            // Bubble keeps pc/bd so an interrupt taken on it reports the right EPC.
            instr_M  <= '0;
            pc_M     <= pc_E;
            alu_M    <= '0;
            wdata_M  <= '0;
            a3_M     <= '0;
            exc_M    <= EXC_INT;
            be_M     <= '0;
            bd_M     <= bd_E;
            valid_M  <= 1'b0;
            mem_op_M <= MEM_NONE;
         end else begin
            instr_M  <= instr_E;
            pc_M     <= pc_E;
            alu_M    <= alu_c_E;
            wdata_M  <= sa_wdata;
            a3_M     <= a3_E;
            exc_M    <= exc_next;
            be_M     <= be_next;
            bd_M     <= bd_E;
            valid_M  <= valid_E;
            mem_op_M <= mem_op_E;
         end
      end
   end

endmodule

// File: tb/tb_em_reg.sv
// tb/tb_em_reg.sv - scoreboard bench for em_reg
module tb_em_reg;
   import em_reg_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr_E, pc_E, alu_c_E, rt_data_E;
   logic [4:0]  a3_E, exc_E;
   logic        bd_E, cal_overflow_E, ov_en_E;
   logic [3:0]  mem_op_E;
   logic        valid_E, stall_M, bubble_E, flush;
   logic [31:0] instr_M, pc_M, alu_M, wdata_M;
   logic [4:0]  a3_M, exc_M;
   logic [3:0]  be_M, mem_op_M;
   logic        bd_M, valid_M;

   always #5 clk = ~clk;

   em_reg dut (
      .clk(clk), .reset(reset),
      .instr_E(instr_E), .pc_E(pc_E), .alu_c_E(alu_c_E), .rt_data_E(rt_data_E),
      .a3_E(a3_E), .exc_E(exc_E), .bd_E(bd_E), .cal_overflow_E(cal_overflow_E),
      .ov_en_E(ov_en_E), .mem_op_E(mem_op_E), .valid_E(valid_E), .stall_M(stall_M),
      .bubble_E(bubble_E), .flush(flush),
      .instr_M(instr_M), .pc_M(pc_M), .alu_M(alu_M), .wdata_M(wdata_M),
      .a3_M(a3_M), .exc_M(exc_M), .be_M(be_M), .bd_M(bd_M), .valid_M(valid_M),
      .mem_op_M(mem_op_M)
   );

   typedef struct packed {
      logic [31:0] instr, pc, alu, wdata;
      logic [4:0]  a3, exc;
      logic [3:0]  be, mem_op;
      logic        bd, valid;
      logic        data_known;
   } exp_t;

   exp_t sb_q[$];
   exp_t mdl;
   int   checks = 0;
   int   errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic exp_t model_next(input exp_t cur);
      exp_t n;
      logic ld, st, mis;
      logic [1:0] a;
      n  = cur;
      a  = alu_c_E[1:0];
      ld = (mem_op_E == MEM_LW) || (mem_op_E == MEM_LH) || (mem_op_E == MEM_LHU) ||
           (mem_op_E == MEM_LB) || (mem_op_E == MEM_LBU);
      st = (mem_op_E == MEM_SW) || (mem_op_E == MEM_SH) || (mem_op_E == MEM_SB);
      if (!reset) begin
         n = '0;
         n.data_known = 1'b1;
      end else if (flush) begin
         n = '0;
      end else if (stall_M) begin
         n = cur;
      end else if (bubble_E) begin
         n = '0;
         n.pc = pc_E;
         n.bd = bd_E;
      end else begin
         n.instr = instr_E; n.pc = pc_E; n.alu = alu_c_E; n.a3 = a3_E;
         n.bd = bd_E; n.valid = valid_E; n.mem_op = mem_op_E; n.data_known = 1'b1;
         mis = 1'b0;
         if (mem_op_E == MEM_LW || mem_op_E == MEM_SW) mis = (a != 2'd0);
         if (mem_op_E == MEM_LH || mem_op_E == MEM_LHU || mem_op_E == MEM_SH) mis = a[0];
         if (exc_E != 5'd0) n.exc = exc_E;
         else if ((ld || st) && (mis || cal_overflow_E)) n.exc = ld ? 5'd4 : 5'd5;
         else if (ov_en_E && cal_overflow_E) n.exc = 5'd12;
         else n.exc = 5'd0;
         n.wdata = rt_data_E;
         n.be = 4'b0000;
         case (mem_op_E)
            MEM_SW: n.be = 4'b1111;
            MEM_SH: begin
               n.wdata = {rt_data_E[15:0], rt_data_E[15:0]};
               n.be = a[1] ? 4'b1100 : 4'b0011;
            end
            MEM_SB: begin
               n.wdata = {rt_data_E[7:0], rt_data_E[7:0], rt_data_E[7:0], rt_data_E[7:0]};
               case (a)
                  2'd0: n.be = 4'b0001;
                  2'd1: n.be = 4'b0010;
                  2'd2: n.be = 4'b0100;
                  default: n.be = 4'b1000;
               endcase
            end
            default: ;
         endcase
         if (!valid_E || n.exc != 5'd0) n.be = 4'b0000;
      end
      return n;
   endfunction

   task automatic step();
      exp_t e;
      mdl = model_next(mdl);
      sb_q.push_back(mdl);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check_val("instr_M", instr_M, e.instr);
      check_val("pc_M", pc_M, e.pc);
      check_val("a3_M", {27'd0, a3_M}, {27'd0, e.a3});
      check_val("exc_M", {27'd0, exc_M}, {27'd0, e.exc});
      check_val("be_M", {28'd0, be_M}, {28'd0, e.be});
      check_val("mem_op_M", {28'd0, mem_op_M}, {28'd0, e.mem_op});
      check_val("bd_M", {31'd0, bd_M}, {31'd0, e.bd});
      check_val("valid_M", {31'd0, valid_M}, {31'd0, e.valid});
      if (e.data_known) begin
         check_val("alu_M", alu_M, e.alu);
         check_val("wdata_M", wdata_M, e.wdata);
      end
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [3:0] op,
                        input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] exc,
                        input logic ovf, input logic oven);
      instr_E = instr; pc_E = pc; mem_op_E = op; alu_c_E = alu; rt_data_E = rt;
      exc_E = exc; cal_overflow_E = ovf; ov_en_E = oven;
      a3_E = instr[20:16]; bd_E = pc[2]; valid_E = 1'b1;
   endtask

   initial begin
      mdl = '0;
      reset = 1'b0; flush = 1'b0; stall_M = 1'b0; bubble_E = 1'b0;
      drive(32'h0, 32'h0, MEM_NONE, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      step(); step();
      check_val("reset_valid", {31'd0, valid_M}, 32'd0);
      check_val("reset_mem_op", {28'd0, mem_op_M}, 32'd0);
      reset = 1'b1;

      drive(32'hA5E1_0000, 32'h0040_0000, MEM_SH, 32'h0000_0006, 32'h1234_ABCD, 5'd0, 1'b0, 1'b0);
      step();
      check_val("sh_wdata", wdata_M, 32'hABCD_ABCD);
      check_val("sh_be", {28'd0, be_M}, 32'hC);
      check_val("sh_exc", {27'd0, exc_M}, 32'd0);

      drive(32'h8C02_0000, 32'h0040_0004, MEM_LW, 32'h2, 32'h0, 5'd0, 1'b0, 1'b0);
      step();
      check_val("lw_adel", {27'd0, exc_M}, 32'd4);
      check_val("lw_be", {28'd0, be_M}, 32'd0);
      drive(32'hAC02_0000, 32'h0040_0008, MEM_SW, 32'h2, 32'h1111_2222, 5'd0, 1'b0, 1'b0);
      step();
      check_val("sw_ades", {27'd0, exc_M}, 32'd5);

      drive(32'h0043_1020, 32'h0040_000C, MEM_NONE, 32'h8000_0000, 32'h0, 5'd0, 1'b1, 1'b1);
      step();
      check_val("add_ov", {27'd0, exc_M}, 32'd12);
      drive(32'h0043_1021, 32'h0040_0010, MEM_NONE, 32'h8000_0000, 32'h0, 5'd0, 1'b1, 1'b0);
      step();
      check_val("addu_noov", {27'd0, exc_M}, 32'd0);
      check_val("addu_alu", alu_M, 32'h8000_0000);

      drive(32'hAC03_0000, 32'h0040_0014, MEM_SW, 32'h1, 32'hDEAD_BEEF, 5'd10, 1'b0, 1'b0);
      step();
      check_val("ri_prio", {27'd0, exc_M}, 32'd10);
      check_val("ri_be", {28'd0, be_M}, 32'd0);

      for (int a = 0; a < 4; a++) begin
         drive(32'hA004_0000, 32'h0040_0020, MEM_SB, 32'h100 + a, 32'h0000_0077, 5'd0, 1'b0, 1'b0);
         step();
      end
      drive(32'hA405_0000, 32'h0040_0024, MEM_SH, 32'h104, 32'h0000_5A5A, 5'd0, 1'b0, 1'b0);
      step();
      drive(32'h8406_0000, 32'h0040_0028, MEM_LH, 32'h105, 32'h0, 5'd0, 1'b0, 1'b0);
      step();
      drive(32'h8007_0000, 32'h0040_002C, MEM_LB, 32'h8000_0000, 32'h0, 5'd0, 1'b1, 1'b0);
      step();
      check_val("ld_ovf_adel", {27'd0, exc_M}, 32'd4);
      drive(32'hAC08_0000, 32'h0040_0030, MEM_SW, 32'h200, 32'h55AA_55AA, 5'd0, 1'b0, 1'b0);
      valid_E = 1'b0;
      step();

      drive(32'hAC09_0000, 32'h0040_0034, MEM_SW, 32'h300, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0);
      step();
      stall_M = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive($urandom, $urandom, 4'($urandom_range(0, 8)), $urandom, $urandom, 5'd0, 1'b0, 1'b0);
         step();
      end
      check_val("stall_instr", instr_M, 32'hAC09_0000);
      check_val("stall_wdata", wdata_M, 32'hCAFE_F00D);
      flush = 1'b1;
      step();
      check_val("flush_valid", {31'd0, valid_M}, 32'd0);
      check_val("flush_instr", instr_M, 32'd0);
      flush = 1'b0; stall_M = 1'b0;

      drive(32'h0100_0000, 32'h0040_0044, MEM_SW, 32'h0, 32'h1, 5'd0, 1'b0, 1'b0);
      bubble_E = 1'b1;
      step();
      check_val("bubble_pc", pc_M, 32'h0040_0044);
      drive(32'h0200_0000, 32'h0040_0048, MEM_LW, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      stall_M = 1'b1;
      step();
      stall_M = 1'b0; bubble_E = 1'b0;

      drive(32'hAC0A_0000, 32'h0040_0050, MEM_SW, 32'h400, 32'h1357_9BDF, 5'd0, 1'b0, 1'b0);
      reset = 1'b0;
      flush = 1'b1;
      step();
      check_val("rst_mid_be", {28'd0, be_M}, 32'd0);
      check_val("rst_mid_pc", pc_M, 32'd0);
      reset = 1'b1; flush = 1'b0;
      drive(32'h8C0B_0000, 32'h0040_0054, MEM_LW, 32'h404, 32'h0, 5'd0, 1'b0, 1'b0);
      step();
      check_val("post_rst_valid", {31'd0, valid_M}, 32'd1);
      check_val("post_rst_a3", {27'd0, a3_M}, 32'd11);

      for (int i = 0; i < 60; i++) begin
         drive($urandom, $urandom, 4'($urandom_range(0, 8)), $urandom, $urandom,
               ($urandom_range(0, 3) == 0) ? 5'd10 : 5'd0, 1'($urandom), 1'($urandom));
         valid_E  = ($urandom_range(0, 5) != 0);
         reset    = ($urandom_range(0, 15) != 0);
         flush    = ($urandom_range(0, 7) == 0);
         stall_M  = ($urandom_range(0, 4) == 0);
         bubble_E = ($urandom_range(0, 4) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
